// File: rtl/vga_timing_pkg.sv
// VGA timing constants and shared types.
// Default mode is 640x480@60 on a 25 MHz pixel clock.
package vga_timing_pkg;

  localparam int DEF_H_VIS  = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;

  localparam int DEF_V_VIS  = 480;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;

  localparam int H_TOTAL =
    DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL =
    DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  typedef logic [9:0] coord_t;

  typedef enum logic [1:0] {
    V_ACT,
    V_FRONT,
    V_SYNC,
    V_BACK
  } v_state_e;

endpackage

// File: rtl/vga_line_decode.sv
// Registered horizontal decode: hsync, gated visibility and pix_x.
// Reusable by any consumer of the upstream h_count.
module vga_line_decode
  import vga_timing_pkg::*;
#(
  parameter int   H_VIS    = DEF_H_VIS,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] h_count,
  input  logic       v_active,
  output logic       h_vis_d,
  output logic       h_range_err,
  output logic       hsync,
  output logic       h_visible,
  output logic [9:0] pix_x
);

  localparam coord_t H_VIS_C = coord_t'(H_VIS);
  localparam coord_t HS_BEG  = coord_t'(H_VIS + H_FP);
  localparam coord_t HS_END  = coord_t'(H_VIS + H_FP + H_SYNC);
  localparam coord_t H_LAST  =
    coord_t'(H_VIS + H_FP + H_SYNC + H_BP - 1);

  logic in_sync;
  logic show;

  // Out-of-range positions fall outside both windows, so they blank.
  assign h_vis_d     = h_count < H_VIS_C;
  assign h_range_err = h_count > H_LAST;
  assign in_sync     = (h_count >= HS_BEG) && (h_count < HS_END);
  assign show        = h_vis_d & v_active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync     <= ~SYNC_POL;
      h_visible <= 1'b0;
      pix_x     <= '0;
    end else begin
      hsync     <= in_sync ? SYNC_POL : ~SYNC_POL;
      h_visible <= show;
      pix_x     <= show ? h_count : '0;
    end
  end

endmodule

// File: rtl/vga_v_sync_gen.sv
// Vertical timing owner: line counter, vertical FSM, output decode
// and upstream interface checks for the VGA path.
module vga_v_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_VIS    = DEF_H_VIS,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_VIS    = DEF_V_VIS,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] h_count,
  input  logic       trig_v,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic [9:0] v_count,
  output logic       frame_start,
  output logic       locked,
  output logic       proto_err
);

  localparam int     H_TOT    = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int     V_TOT    = V_VIS + V_FP + V_SYNC + V_BP;
  localparam coord_t H_TOT_C  = coord_t'(H_TOT);
  localparam coord_t V_LAST   = coord_t'(V_TOT - 1);
  localparam coord_t V_VIS_C  = coord_t'(V_VIS);
  localparam coord_t V_FP_BEG = coord_t'(V_VIS);
  localparam coord_t V_SY_BEG = coord_t'(V_VIS + V_FP);
  localparam coord_t V_BP_BEG = coord_t'(V_VIS + V_FP + V_SYNC);

  v_state_e state_q;
  v_state_e state_d;
  coord_t   v_next;
  coord_t   since_q;
  coord_t   since_d;
  coord_t   pix_y_d;
  logic     locked_next;
  logic     v_active;
  logic     h_vis_d;
  logic     h_range_err;
  logic     vsync_d;
  logic     frame_d;
  logic     err_d;

  // The V_SYNC parameter shadows the enum literal, hence the scoping.
  always_comb begin
    v_next      = v_count;
    locked_next = locked;
    state_d     = state_q;
    if (trig_v) begin
      locked_next = 1'b1;
      if (!locked || v_count == V_LAST) begin
        v_next = '0;
      end else begin
        v_next = v_count + 1'b1;
      end
      unique case (1'b1)
        (v_next == V_FP_BEG): state_d = vga_timing_pkg::V_FRONT;
        (v_next == V_SY_BEG): state_d = vga_timing_pkg::V_SYNC;
        (v_next == V_BP_BEG): state_d = vga_timing_pkg::V_BACK;
        (v_next == '0):       state_d = vga_timing_pkg::V_ACT;
        default:              state_d = state_q;
      endcase
    end
  end

  always_comb begin
    since_d = since_q;
    if (trig_v) begin
      since_d = coord_t'(1);
    end else if (since_q != H_TOT_C) begin
      since_d = since_q + 1'b1;
    end
  end

  always_comb begin
    v_active = locked_next & (v_next < V_VIS_C);
    vsync_d  = ~SYNC_POL;
    if (locked_next && state_d == vga_timing_pkg::V_SYNC) begin
      vsync_d = SYNC_POL;
    end
    frame_d = trig_v & locked & (v_next == '0);
    pix_y_d = (v_active & h_vis_d) ? v_next : '0;
    err_d   = proto_err | h_range_err;
    if (trig_v && h_count != '0) begin
      err_d = 1'b1;
    end
    // since_q holds the edge distance to the previous strobe here.
    if (trig_v && locked && since_q < H_TOT_C) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= vga_timing_pkg::V_ACT;
      v_count     <= '0;
      since_q     <= '0;
      locked      <= 1'b0;
      vsync       <= ~SYNC_POL;
      pix_y       <= '0;
      frame_start <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      state_q     <= state_d;
      v_count     <= v_next;
      since_q     <= since_d;
      locked      <= locked_next;
      vsync       <= vsync_d;
      pix_y       <= pix_y_d;
      frame_start <= frame_d;
      proto_err   <= err_d;
    end
  end

  vga_line_decode #(
    .H_VIS    (H_VIS),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .SYNC_POL (SYNC_POL)
  ) u_line (
    .clk         (clk),
    .rst_n       (rst_n),
    .h_count     (h_count),
    .v_active    (v_active),
    .h_vis_d     (h_vis_d),
    .h_range_err (h_range_err),
    .hsync       (hsync),
    .h_visible   (video_on),
    .pix_x       (pix_x)
  );

endmodule

// File: tb/tb_vga_v_sync_gen.sv
// Bench for vga_v_sync_gen: directed and random upstream traffic
// checked every cycle against a line-number reference model.
module tb_vga_v_sync_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] h_count;
  logic       trig_v;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic [9:0] v_count;
  logic       frame_start;
  logic       locked;
  logic       proto_err;

  int n_tests = 0;
  int n_fail  = 0;

  int cyc      = 0;
  int m_last   = 0;
  int m_line   = 0;
  bit m_locked = 1'b0;
  bit m_err    = 1'b0;

  always #5 clk = ~clk;

  vga_v_sync_gen dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .h_count     (h_count),
    .trig_v      (trig_v),
    .hsync       (hsync),
    .vsync       (vsync),
    .video_on    (video_on),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .v_count     (v_count),
    .frame_start (frame_start),
    .locked      (locked),
    .proto_err   (proto_err)
  );

  task automatic chk(input string tag, input logic [9:0] got,
                     input logic [9:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d (cycle %0d)",
             tag, got, exp, cyc);
    end
  endtask

  task automatic check_all(input int h, input bit fs);
    bit vis;
    bit hs_act;
    bit vs_act;
    vis    = m_locked && h < 640 && m_line < 480;
    hs_act = h >= 656 && h < 752;
    vs_act = m_locked && m_line >= 490 && m_line < 492;
    chk("hsync",       10'(hsync),       hs_act ? 10'd0 : 10'd1);
    chk("vsync",       10'(vsync),       vs_act ? 10'd0 : 10'd1);
    chk("video_on",    10'(video_on),    10'(vis));
    chk("pix_x",       pix_x,            vis ? 10'(h) : 10'd0);
    chk("pix_y",       pix_y,            vis ? 10'(m_line) : 10'd0);
    chk("v_count",     v_count,          10'(m_line));
    chk("frame_start", 10'(frame_start), 10'(fs));
    chk("locked",      10'(locked),      10'(m_locked));
    chk("proto_err",   10'(proto_err),   10'(m_err));
  endtask

  task automatic step(input int h, input bit t);
    bit was;
    h_count = 10'(h);
    trig_v  = t;
    @(posedge clk);
    cyc++;
    was = m_locked;
    if (t) begin
      if (m_locked && (cyc - m_last) < 800) m_err = 1'b1;
      if (h != 0) m_err = 1'b1;
      m_line   = m_locked ? (m_line + 1) % 525 : 0;
      m_locked = 1'b1;
      m_last   = cyc;
    end
    if (h > 799) m_err = 1'b1;
    #1;
    check_all(h, t && was && m_line == 0);
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_hsync",    10'(hsync),       10'd1);
    chk("rst_vsync",    10'(vsync),       10'd1);
    chk("rst_video_on", 10'(video_on),    10'd0);
    chk("rst_pix_x",    pix_x,            10'd0);
    chk("rst_pix_y",    pix_y,            10'd0);
    chk("rst_v_count",  v_count,          10'd0);
    chk("rst_frame",    10'(frame_start), 10'd0);
    chk("rst_locked",   10'(locked),      10'd0);
    chk("rst_err",      10'(proto_err),   10'd0);
    m_line   = 0;
    m_locked = 1'b0;
    m_err    = 1'b0;
    repeat (hold) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic clean_line();
    for (int h = 0; h < 800; h++) step(h, h == 0);
  endtask

  initial begin
    rst_n   = 1'b1;
    h_count = '0;
    trig_v  = 1'b0;
    #2;
    do_reset(3);

    // Unlocked: hsync decodes, everything vertical stays idle.
    repeat (20) step(int'($urandom_range(0, 799)), 1'b0);

    // Clean lines 0..2, then line 3 with hsync edge probes.
    repeat (3) clean_line();
    step(0, 1'b1);
    step(655, 1'b0);
    step(656, 1'b0);
    step(751, 1'b0);
    step(752, 1'b0);
    step(640, 1'b0);
    step(639, 1'b0);
    repeat (800) step(int'($urandom_range(0, 799)), 1'b0);

    // Misplaced strobe after a legal gap.
    step(37, 1'b1);
    chk("err_h37", 10'(proto_err), 10'd1);

    // Fast line advance through two wraps, with random h jitter.
    for (int l = 0; l < 1100; l++) begin
      int k;
      int h0;
      k  = int'($urandom_range(0, 2));
      h0 = ($urandom_range(0, 7) == 0) ?
           int'($urandom_range(0, 1023)) : 0;
      step(h0, 1'b1);
      for (int j = 0; j < k; j++)
        step(int'($urandom_range(0, 1023)), 1'b0);
    end

    // Reach line 300, reset mid-line, then relock.
    for (int g = 0; g < 600 && m_line != 300; g++) step(0, 1'b1);
    chk("at_line_300", v_count, 10'd300);
    step(123, 1'b0);
    do_reset(3);
    repeat (30) step(int'($urandom_range(0, 799)), 1'b0);
    step(0, 1'b1);
    chk("relock_pix_y", pix_y, 10'd0);
    chk("relock_video", 10'(video_on), 10'd1);
    for (int h = 1; h < 800; h++) step(h, 1'b0);
    clean_line();
    repeat (200) step(int'($urandom_range(0, 799)), 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
